fifo_reader: RTL and testbench

// - Drains the BRAM-backed sample FIFO: issues out_req pulses, tracks the fixed BRAM read latency, presents words on valid/ready.
// - Sits between the sample FIFO read port and the readout path (UART TX / bridge).
// - Upstream has no backpressure once a read is issued; a credit-limited skid buffer absorbs every in-flight word.

---
 rtl/fifo_reader_pkg.sv | 21 ++
 rtl/fifo_reader_skid.sv | 58 +++++
 rtl/fifo_reader.sv | 122 ++++++++++++
 tb/tb_fifo_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and helpers for the sample-FIFO drain engine.
// Holds the FSM state encoding, the default BRAM read latency and the credit check.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_READ_LATENCY = 3;

  // A new read may only launch if every word already owed still fits in the skid.
  function automatic logic credit_ok(input int unsigned occ,
                                     input int unsigned inflight,
                                     input int unsigned depth);
    return (occ + inflight) < depth;
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Skid buffer behind the BRAM read port: SKID_DEPTH storage entries plus an output head register.
// occ counts storage entries only; the head register is what drives the downstream valid/data.
module fifo_reader_skid #(
  parameter int WIDTH      = 8,
  parameter int SKID_DEPTH = 4,
  parameter int OW         = $clog2(SKID_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [OW-1:0]    occ
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  logic [SKID_DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic take, bypass, st_push, st_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Head register reloads when empty or being consumed; storage is drained before a bypass.
  assign take    = ~head_valid | pop;
  assign bypass  = push & take & (occ == '0);
  assign st_pop  = take & (occ != '0);
  assign st_push = push & ~bypass;

  always_ff @(posedge clk) begin
    if (st_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      occ        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (st_push) wr_ptr <= ptr_inc(wr_ptr);
      if (st_pop) begin
        head_data <= mem[rd_ptr];
        rd_ptr    <= ptr_inc(rd_ptr);
      end else if (bypass) begin
        head_data <= push_data;
      end
      if (take) head_valid <= st_pop | bypass;
      occ <= occ + OW'(st_push) - OW'(st_pop);
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Drains the BRAM-backed sample FIFO onto a valid/ready stream.
// Reads are credit-limited so every word in flight always has a skid slot waiting for it.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int SKID_DEPTH   = 4,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW:0]      count,
  input  logic             abort,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_out,
  output logic             fifo_out_req,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      delivered
);

  localparam int OW = $clog2(SKID_DEPTH + 1);
  localparam int IW = $clog2(READ_LATENCY + 1);
  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

  if (SKID_DEPTH < READ_LATENCY + 1) begin : g_bad_cfg
    $error("fifo_reader: SKID_DEPTH must be >= READ_LATENCY+1");
  end

  state_t state, state_nxt;
  logic [AW:0]             remaining;
  logic                    count_mode;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [IW-1:0]           inflight;
  logic [OW-1:0]           skid_occ;
  logic                    skid_vld;
  logic [WIDTH-1:0]        skid_data;
  logic                    req, xfer, can_issue;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + IW'(vld_pipe[i]);
  end

  assign can_issue = credit_ok(32'(skid_occ), 32'(inflight), SKID_DEPTH);
  assign req = (state == DRAIN) & ~abort & ~fifo_empty
             & ((remaining != '0) | ~count_mode) & can_issue;
  assign xfer = skid_vld & ready;

  assign fifo_out_req = req;
  assign data         = skid_data;
  assign valid        = skid_vld;
  assign busy         = (state == DRAIN) | (state == FLUSH);
  assign done         = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = DRAIN;
      DRAIN: begin
        if (abort)                                   state_nxt = FLUSH;
        else if (count_mode && remaining == '0)      state_nxt = FLUSH;
        else if (!count_mode && fifo_empty && !req)  state_nxt = FLUSH;
      end
      FLUSH: if (inflight == '0 && skid_occ == '0 && !skid_vld) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Bit READ_LATENCY-1 marks the cycle the requested word sits on fifo_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= req;
      for (int i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining  <= '0;
      count_mode <= 1'b0;
      delivered  <= '0;
    end else if (state == IDLE && start) begin
      remaining  <= count;
      count_mode <= (count != '0);
      delivered  <= '0;
    end else begin
      if (req && count_mode) remaining <= remaining - CNT_ONE;
      if (xfer && delivered != '1) delivered <= delivered + CNT_ONE;
    end
  end

  fifo_reader_skid #(
    .WIDTH      (WIDTH),
    .SKID_DEPTH (SKID_DEPTH),
    .OW         (OW)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (vld_pipe[READ_LATENCY-1]),
    .push_data  (fifo_out),
    .pop        (xfer),
    .head_data  (skid_data),
    .head_valid (skid_vld),
    .occ        (skid_occ)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader paired with a 16-deep, 3-cycle-latency sample FIFO model.
// Expected words come from a queue mirroring FIFO contents in write order.
module tb_fifo_reader;

  localparam int W = 8, D = 16, RL = 3, SD = 4, AW = 4;

  logic clk = 1'b0;
  logic rst, start, abort, ready, fifo_empty, fifo_out_req, valid, busy, done;
  logic [AW:0] count, delivered;
  logic [W-1:0] fifo_out, data;

  always #5 clk = ~clk;

  fifo_reader #(.WIDTH(W), .DEPTH(D), .READ_LATENCY(RL), .SKID_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_out(fifo_out), .fifo_out_req(fifo_out_req),
    .data(data), .valid(valid), .ready(ready), .busy(busy), .done(done),
    .delivered(delivered)
  );

  // sample FIFO: data appears on fifo_out RL cycles after the request cycle
  logic [W-1:0] mem [D];
  logic [AW:0]  wp = '0, rp = '0;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0, rd1 = '0, rd2 = '0, fout = '0;
  always @(posedge clk) begin
    if (wr_en) begin mem[wp[AW-1:0]] <= wr_data; wp <= wp + 1'b1; end
    if (fifo_out_req) begin rd1 <= mem[rp[AW-1:0]]; rp <= rp + 1'b1; end
    rd2  <= rd1;
    fout <= rd2;
  end
  assign fifo_empty = (wp == rp);
  assign fifo_out   = fout;

  int total = 0, bad = 0;
  int cyc = 0, s_cyc = 0, nreq = 0, nxfer = 0, ndone = 0, first_v = -1, maxcred = 0, rmode = 0;
  logic [W-1:0] fq[$], exp_q[$], dlog[$], exp_words[$], snap[$];
  int xcyc[$];
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [W-1:0] prev_d = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic observe();
    logic [W-1:0] w;
    int cred;
    w = '0;
    if (fifo_out_req) begin
      chk("req_nonempty", 32'(fifo_empty), 32'(0));
      if (fq.size() > 0) w = fq.pop_front();
    end
    if (rst) begin
      exp_q.delete();
      nreq = 0; nxfer = 0; prev_v = 1'b0;
    end else begin
      cred = nreq - nxfer - int'(valid);
      if (cred > maxcred) maxcred = cred;
      if (prev_v && !prev_r) begin
        chk("hold_valid", 32'(valid), 32'(1));
        chk("hold_data", 32'(data), 32'(prev_d));
      end
      if (fifo_out_req) begin exp_q.push_back(w); nreq++; end
      if (valid && first_v < 0) first_v = cyc;
      if (valid && ready) begin
        chk("xfer_pending", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) chk("xfer_data", 32'(data), 32'(exp_q.pop_front()));
        dlog.push_back(data);
        xcyc.push_back(cyc);
        nxfer++;
      end
      if (done) ndone++;
      prev_v = valid; prev_r = ready; prev_d = data;
    end
  endtask

  task automatic tick();
    #1;
    observe();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_ready();
    case (rmode)
      1: ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2: ready = 1'($urandom_range(1));
      default: ready = 1'b1;
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) begin drive_ready(); tick(); end
  endtask

  task automatic clear_stats();
    nreq = 0; nxfer = 0; ndone = 0; first_v = -1; maxcred = 0;
    dlog.delete(); xcyc.delete(); exp_words.delete();
  endtask

  task automatic fifo_push(input logic [W-1:0] v);
    wr_en = 1'b1; wr_data = v; fq.push_back(v);
    drive_ready(); tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input int c);
    count = (AW+1)'(c); start = 1'b1; s_cyc = cyc + 1;
    drive_ready(); tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (ndone == 0 && k < budget) begin drive_ready(); tick(); k++; end
    run(3);
    chk("done_pulses", 32'(ndone), 32'(1));
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_len"}, 32'(dlog.size()), 32'(exp_words.size()));
    for (int i = 0; i < dlog.size() && i < exp_words.size(); i++)
      chk(tag, 32'(dlog[i]), 32'(exp_words[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1; count = '0;
    run(3);
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_delivered", 32'(delivered), 32'(0));
    chk("rst_req", 32'(fifo_out_req), 32'(0));
    chk("rst_data", 32'(data), 32'(0));
    rst = 1'b0;
    run(2);

    // counted drain of a known ramp at full rate
    clear_stats();
    for (int i = 0; i < 8; i++) fifo_push(W'(8'h10 + i));
    clear_stats();
    for (int i = 0; i < 8; i++) exp_words.push_back(W'(8'h10 + i));
    do_start(8);
    wait_done(60);
    cmp_log("t1_word");
    chk("t1_first_lat", 32'(first_v - s_cyc), 32'(RL + 1));
    if (xcyc.size() == 8) chk("t1_span", 32'(xcyc[7] - xcyc[0]), 32'(7));
    chk("t1_delivered", 32'(delivered), 32'(8));
    chk("t1_busy", 32'(busy), 32'(0));

    // drain until empty
    clear_stats();
    for (int i = 0; i < 8; i++) begin v = W'($urandom_range(255)); fifo_push(v); end
    clear_stats();
    exp_words = fq;
    do_start(0);
    wait_done(80);
    cmp_log("t2_word");
    chk("t2_delivered", 32'(delivered), 32'(8));
    chk("t2_empty", 32'(fifo_empty), 32'(1));

    // backpressure: fixed 1-0-0-1 pattern, then random ready
    for (int m = 1; m <= 2; m++) begin
      rmode = m;
      clear_stats();
      for (int i = 0; i < 8; i++) begin v = W'($urandom_range(255)); fifo_push(v); end
      clear_stats();
      exp_words = fq;
      do_start(8);
      wait_done(200);
      cmp_log("t3_word");
      chk("t3_delivered", 32'(delivered), 32'(8));
      chk("t3_credit", 32'(maxcred <= SD), 32'(1));
    end
    rmode = 0;

    // counted drain stalls on an empty FIFO until more data arrives
    clear_stats();
    for (int i = 0; i < 3; i++) begin v = W'($urandom_range(255)); fifo_push(v); end
    clear_stats();
    exp_words = fq;
    do_start(6);
    run(25);
    chk("t4_partial", 32'(delivered), 32'(3));
    chk("t4_busy", 32'(busy), 32'(1));
    chk("t4_no_done", 32'(ndone), 32'(0));
    count = 5'd1; start = 1'b1; drive_ready(); tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = W'($urandom_range(255)); exp_words.push_back(v); fifo_push(v);
    end
    wait_done(60);
    cmp_log("t4_word");
    chk("t4_delivered", 32'(delivered), 32'(6));
    abort = 1'b1; run(3); abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'(0));

    // abort mid-drain: in-flight words still come out
    clear_stats();
    for (int i = 0; i < 16; i++) begin v = W'($urandom_range(255)); fifo_push(v); end
    clear_stats();
    snap = fq;
    do_start(16);
    while (cyc < s_cyc + 5) run(1);
    abort = 1'b1; run(1); abort = 1'b0;
    wait_done(60);
    for (int i = 0; i < nreq && i < snap.size(); i++) exp_words.push_back(snap[i]);
    cmp_log("t5_word");
    chk("t5_reqs", 32'(nreq), 32'(5));
    chk("t5_delivered", 32'(delivered), 32'(nreq));
    chk("t5_short", 32'(delivered < 16), 32'(1));
    chk("t5_left", 32'(fifo_empty), 32'(0));

    // reset with words in flight, then resume from the FIFO's read position
    clear_stats();
    do_start(0);
    run(5);
    rst = 1'b1; drive_ready(); tick();
    chk("t6_valid", 32'(valid), 32'(0));
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_delivered", 32'(delivered), 32'(0));
    chk("t6_req", 32'(fifo_out_req), 32'(0));
    rst = 1'b0;
    run(2);
    clear_stats();
    exp_words = fq;
    do_start(0);
    wait_done(80);
    cmp_log("t6_word");
    chk("t6_total", 32'(delivered), 32'(exp_words.size()));
    chk("t6_empty", 32'(fifo_empty), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
